// File: rtl/rx_link_reset.sv
// GTX receive-side link bring-up sequencer: CDR, PCS and elastic-buffer resets, then alignment qualification.
// Optional feature: define RX_ERR_CNT_EN to build the saturating recovery counter behind RX_ERR_CNT.
module rx_link_reset #(
  parameter int CDR_DLY_LONG  = 2047,
  parameter int CDR_DLY_SHORT = 127,
  parameter int ALIGN_TMO     = 4095,
  parameter int RST_PULSE     = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PLLLKDET,
  input  logic       RX_RATE,
  input  logic       INIT,
  input  logic       RXBYTEISALIGNED,
  input  logic [2:0] RXBUFSTATUS,
  output logic       RXCDRRESET,
  output logic       RXRESET,
  output logic       RXBUFRESET,
  output logic       RX_READY,
  output logic [7:0] RX_ERR_CNT
);

  localparam int MAX_A   = (CDR_DLY_LONG > CDR_DLY_SHORT) ? CDR_DLY_LONG : CDR_DLY_SHORT;
  localparam int MAX_B   = (ALIGN_TMO > RST_PULSE) ? ALIGN_TMO : RST_PULSE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(CDR_DLY_LONG);
  localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(CDR_DLY_SHORT);
  localparam logic [CNT_W-1:0] LD_TMO   = CNT_W'(ALIGN_TMO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    CDR_RST,
    CDR_WAIT,
    PCS_RST,
    BUF_RST,
    WAIT_ALIGN,
    READY
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       acnt_q, acnt_d;
  logic             lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
  logic             algn_s1_q, algn_s1_d, algn_s2_q, algn_s2_d;
  logic             cdr_q, cdr_d, pcs_q, pcs_d, bufr_q, bufr_d, rdy_q, rdy_d;
  logic             buf_err, cnt_zero;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      acnt_q    <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      algn_s1_q <= 1'b0;
      algn_s2_q <= 1'b0;
      cdr_q     <= 1'b0;
      pcs_q     <= 1'b0;
      bufr_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acnt_q    <= acnt_d;
      lock_s1_q <= lock_s1_d;
      lock_s2_q <= lock_s2_d;
      algn_s1_q <= algn_s1_d;
      algn_s2_q <= algn_s2_d;
      cdr_q     <= cdr_d;
      pcs_q     <= pcs_d;
      bufr_q    <= bufr_d;
      rdy_q     <= rdy_d;
    end
  end

  always_comb begin
    lock_s1_d = PLLLKDET;
    lock_s2_d = lock_s1_q;
    algn_s1_d = RXBYTEISALIGNED;
    algn_s2_d = algn_s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    acnt_d    = '0;
    buf_err   = (RXBUFSTATUS == 3'b101) || (RXBUFSTATUS == 3'b110);
    cnt_zero  = (cnt_q == '0);

    // Each timed state is entered with its counter preloaded and leaves on the cycle it reads zero.
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s2_q) begin
          state_d = CDR_RST;
          cnt_d   = LD_PULSE;
        end
      end
      CDR_RST: begin
        if (cnt_zero) begin
          state_d = CDR_WAIT;
          cnt_d   = RX_RATE ? LD_SHORT : LD_LONG;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CDR_WAIT: begin
        if (cnt_zero) begin
          state_d = PCS_RST;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PCS_RST: begin
        if (cnt_zero) begin
          state_d = BUF_RST;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      BUF_RST: begin
        if (cnt_zero) begin
          state_d = WAIT_ALIGN;
          cnt_d   = LD_TMO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WAIT_ALIGN: begin
        // Alignment on the eighth consecutive cycle wins over a timeout landing on the same cycle.
        if (algn_s2_q && (acnt_q == 3'd7)) begin
          state_d = READY;
        end else if (cnt_zero) begin
          state_d = CDR_RST;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (algn_s2_q) acnt_d = acnt_q + 3'd1;
        end
      end
      READY: begin
        if (buf_err) begin
          state_d = BUF_RST;
          cnt_d   = LD_PULSE;
        end else if (!algn_s2_q) begin
          state_d = WAIT_ALIGN;
          cnt_d   = LD_TMO;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    if (!lock_s2_q || INIT) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      acnt_d  = '0;
    end

    cdr_d  = (state_d == CDR_RST);
    pcs_d  = (state_d == PCS_RST);
    bufr_d = (state_d == BUF_RST);
    rdy_d  = (state_q == READY) && (state_d == READY);
  end

  assign RXCDRRESET = cdr_q;
  assign RXRESET    = pcs_q;
  assign RXBUFRESET = bufr_q;
  assign RX_READY   = rdy_q;

`ifdef RX_ERR_CNT_EN
  logic [7:0] err_q, err_d;
  logic       err_inc;

  // Recoveries are the alignment timeout and any exit from READY other than a restart to WAIT_LOCK.
  always_comb begin
    err_inc = ((state_q == WAIT_ALIGN) && (state_d == CDR_RST)) ||
              ((state_q == READY) && (state_d != READY) && (state_d != WAIT_LOCK));
    err_d   = err_q;
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= '0;
    else        err_q <= err_d;
  end

  assign RX_ERR_CNT = err_q;
`else
  assign RX_ERR_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_rx_link_reset.sv
// Scoreboard bench for rx_link_reset: stimulus queues expected output events, a monitor matches them.
`timescale 1ns/1ps
module tb_rx_link_reset;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PLLLKDET = 1'b0;
  logic       RX_RATE = 1'b0;
  logic       INIT = 1'b0;
  logic       RXBYTEISALIGNED = 1'b0;
  logic [2:0] RXBUFSTATUS = 3'b000;
  logic       RXCDRRESET, RXRESET, RXBUFRESET, RX_READY;
  logic [7:0] RX_ERR_CNT;

`ifdef RX_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int DLY_LONG  = 2047;
  localparam int DLY_SHORT = 127;
  localparam int TMO       = 4095;
  localparam int PW        = 4;
  // Timeline rules: 2 sync flops + 1 registered output; the CDR wait counts DLY..0;
  // READY needs 8 aligned cycles, then one READY cycle before RX_READY shows.
  localparam int SYNC_GAP  = 3;
  localparam int ALIGN_GAP = 8 + 2;
  localparam int TMO_GAP   = TMO + 1;

  localparam int EV_CDR  = 0;
  localparam int EV_PCS  = 1;
  localparam int EV_BUF  = 2;
  localparam int EV_RISE = 3;
  localparam int EV_FALL = 4;

  typedef struct {
    int kind;
    int width;
    int gap;
    int err;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  err_events = 0;
  int  mark_val = 0;
  int  mark_seq = 0;

  rx_link_reset dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .PLLLKDET        (PLLLKDET),
    .RX_RATE         (RX_RATE),
    .INIT            (INIT),
    .RXBYTEISALIGNED (RXBYTEISALIGNED),
    .RXBUFSTATUS     (RXBUFSTATUS),
    .RXCDRRESET      (RXCDRRESET),
    .RXRESET         (RXRESET),
    .RXBUFRESET      (RXBUFRESET),
    .RX_READY        (RX_READY),
    .RX_ERR_CNT      (RX_ERR_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int exp_err();
    if (!ERR_EN) return 0;
    return (err_events > 255) ? 255 : err_events;
  endfunction

  function automatic int cdr_gap(input logic rate);
    return (rate ? DLY_SHORT : DLY_LONG) + 2;
  endfunction

  function automatic logic [2:0] rnd_benign();
    logic [2:0] v;
    v = 3'($urandom_range(0, 7));
    if (v == 3'b101 || v == 3'b110) v = 3'b000;
    return v;
  endfunction

  task automatic push(input int kind, input int width, input int gap);
    ev_t e;
    e.kind  = kind;
    e.width = width;
    e.gap   = gap;
    e.err   = exp_err();
    exp_q.push_back(e);
  endtask

  task automatic bringup(input int first_gap, input logic rate);
    push(EV_CDR, PW, first_gap);
    push(EV_PCS, PW, cdr_gap(rate));
    push(EV_BUF, PW, 1);
    push(EV_RISE, 0, ALIGN_GAP);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_mark();
    mark_val = cyc;
    mark_seq++;
  endtask

  task automatic check_val(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_rxcdrreset"}, int'(RXCDRRESET), 0);
    check_val({tag, "_rxreset"},    int'(RXRESET), 0);
    check_val({tag, "_rxbufreset"}, int'(RXBUFRESET), 0);
    check_val({tag, "_rx_ready"},   int'(RX_READY), 0);
    check_val({tag, "_err_cnt"},    int'(RX_ERR_CNT), exp_err());
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s: %0d expected events still pending after %0d cycles, required 0",
               tag, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic async_reset();
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    err_events = 0;
    check_idle("async_rst");
    tick(3);
    set_mark();
    RST_N = 1'b1;
  endtask

  task automatic buf_error(input logic [2:0] code);
    set_mark();
    RXBUFSTATUS = code;
    err_events++;
    push(EV_FALL, 0, 1);
    push(EV_BUF, PW, 0);
    push(EV_RISE, 0, ALIGN_GAP);
    tick(1);
    RXBUFSTATUS = 3'b000;
    drain(60, "buf_err");
  endtask

  // Monitor: turns output edges into events and matches them against the expected queue.
  logic [2:0] pprev = 3'b000;
  logic [2:0] pcur;
  logic       rprev = 1'b0;
  int         pstart[3];
  int         mark = 0;
  int         seen_seq = 0;

  task automatic got(input int kind, input int width, input int gap);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: kind=%0d width=%0d gap=%0d err=%0d at cycle %0d, required none",
               kind, width, gap, RX_ERR_CNT, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.width != width || e.gap != gap || e.err != int'(RX_ERR_CNT)) begin
        failures++;
        $display("FAIL event_cycle_%0d: got kind=%0d width=%0d gap=%0d err=%0d, required kind=%0d width=%0d gap=%0d err=%0d",
                 cyc, kind, width, gap, RX_ERR_CNT, e.kind, e.width, e.gap, e.err);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (seen_seq != mark_seq) begin
        mark     = mark_val;
        seen_seq = mark_seq;
      end
      if (!RST_N) begin
        pprev = 3'b000;
        rprev = 1'b0;
      end else begin
        pcur = {RXBUFRESET, RXRESET, RXCDRRESET};
        for (int k = 0; k < 3; k++) begin
          if (pcur[k] && !pprev[k]) pstart[k] = cyc;
          if (!pcur[k] && pprev[k]) begin
            got(k, cyc - pstart[k], pstart[k] - mark);
            mark = cyc - 1;
          end
        end
        if (RX_READY && !rprev) begin
          got(EV_RISE, 0, cyc - mark);
          mark = cyc;
        end
        if (!RX_READY && rprev) begin
          got(EV_FALL, 0, cyc - mark);
          mark = cyc;
        end
        pprev = pcur;
        rprev = RX_READY;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic rate;
    int   w;

    // Reset values, then idle in WAIT_LOCK with no lock.
    tick(3);
    check_idle("reset");
    RST_N = 1'b1;
    tick(3);
    check_idle("wait_lock");

    // Long CDR bring-up.
    RXBYTEISALIGNED = 1'b1;
    RX_RATE = 1'b0;
    tick(4);
    set_mark();
    PLLLKDET = 1'b1;
    bringup(SYNC_GAP, 1'b0);
    drain(2300, "long_bringup");

    // Benign buffer status in READY, then an overflow.
    repeat ($urandom_range(3, 12)) begin
      RXBUFSTATUS = rnd_benign();
      tick(1);
    end
    buf_error(3'b110);

    // Alignment loss, a short alignment glitch, then recovery.
    set_mark();
    RXBYTEISALIGNED = 1'b0;
    err_events++;
    push(EV_FALL, 0, SYNC_GAP);
    drain(20, "align_drop");
    tick($urandom_range(5, 30));
    w = $urandom_range(1, 7);
    RXBYTEISALIGNED = 1'b1;
    tick(w);
    RXBYTEISALIGNED = 1'b0;
    tick(4);
    set_mark();
    RXBYTEISALIGNED = 1'b1;
    push(EV_RISE, 0, SYNC_GAP + 8);
    drain(40, "align_back");

    // INIT restart with the short CDR delay.
    RX_RATE = 1'b1;
    tick(1);
    set_mark();
    INIT = 1'b1;
    push(EV_FALL, 0, 1);
    bringup(1, 1'b1);
    tick(1);
    INIT = 1'b0;
    drain(300, "init_short");

    // Fresh reset with alignment absent: timeout and CDR re-pulse.
    RXBYTEISALIGNED = 1'b0;
    RX_RATE = 1'b1;
    async_reset();
    push(EV_CDR, PW, SYNC_GAP);
    push(EV_PCS, PW, cdr_gap(1'b1));
    push(EV_BUF, PW, 1);
    err_events++;
    push(EV_CDR, PW, TMO_GAP);
    drain(4600, "timeout");
    RXBYTEISALIGNED = 1'b1;
    push(EV_PCS, PW, cdr_gap(1'b1));
    push(EV_BUF, PW, 1);
    push(EV_RISE, 0, ALIGN_GAP);
    drain(300, "after_timeout");

    // Lock loss plus buffer error while in CDR_WAIT.
    rate = 1'($urandom_range(0, 1));
    RX_RATE = rate;
    tick(1);
    set_mark();
    INIT = 1'b1;
    push(EV_FALL, 0, 1);
    push(EV_CDR, PW, 1);
    tick(1);
    INIT = 1'b0;
    drain(20, "init_to_cdr");
    tick($urandom_range(2, 40));
    set_mark();
    PLLLKDET = 1'b0;
    RXBUFSTATUS = 3'b101;
    tick(3);
    RXBUFSTATUS = 3'b000;
    tick(8);
    check_idle("lock_drop");
    rate = 1'($urandom_range(0, 1));
    RX_RATE = rate;
    set_mark();
    PLLLKDET = 1'b1;
    bringup(SYNC_GAP, rate);
    drain(2300, "relock");

    // Asynchronous reset while READY.
    repeat ($urandom_range(1, 20)) begin
      RXBUFSTATUS = rnd_benign();
      tick(1);
    end
    RXBUFSTATUS = 3'b000;
    rate = 1'($urandom_range(0, 1));
    RX_RATE = rate;
    async_reset();
    bringup(SYNC_GAP, rate);
    drain(2300, "post_reset");

    // 300 forced buffer errors: counter saturates when enabled.
    repeat (300) begin
      repeat ($urandom_range(0, 3)) begin
        RXBUFSTATUS = rnd_benign();
        tick(1);
      end
      buf_error(($urandom_range(0, 1) != 0) ? 3'b101 : 3'b110);
    end
    check_val("err_saturation", int'(RX_ERR_CNT), exp_err());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
